audio_adc_capture: RTL and testbench

AUDIO_ADC_CAPTURE -- requirements
Module: audio_adc_capture

---
 rtl/audio_adc_capture.sv | 248 ++++++++++++++++++++++++
 tb/tb_audio_adc_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_capture.sv
// ---------------------------------------------------------------------------
// audio_adc_capture
//   Captures serial audio from a codec ADC port (I2S or left-justified) into
//   a small sample FIFO.
//   The codec BCLK, ADCLRCK and ADCDAT inputs are asynchronous to clk_clk.
//   All three pass through matching 2-flop synchronisers, so the data bit
//   stays aligned with the bit clock.
//
// Parameters
//   SAMPLE_W   captured sample width (8..32)
//   CHANNELS   1 = left only (right words dropped), 2 = left + right
//   FIFO_DEPTH sample FIFO entries (power of 2, 4..256)
//   MODE       0 = I2S (one BCLK delay after ADCLRCK edge), 1 = left-justified
//
// Ports
//   clk_clk, reset_reset     system clock, synchronous active-high reset
//   audio_interface_*        codec BCLK / ADCLRCK (0 left, 1 right) / ADCDAT
//   out_valid/out_ready      FIFO head handshake (see below)
//   out_data, out_channel    sample at FIFO head and its channel
//   overflow, ovf_clr        sticky "word dropped on full FIFO" flag + clear
//   fill_level               FIFO occupancy
//   fsm_state                capture FSM state (0 IDLE, 1 SKIP, 2 SHIFT, 3 HOLD)
//
// Optional feature (macro AUDIO_ADC_CAPTURE_LEVEL_METER_EN)
//   peak_l, peak_r           per-channel peak magnitude of captured words
//   peak_clr                 zeroes both peaks
//
// Handshake: a word leaves the FIFO on every rising clk edge where
// out_valid and out_ready are both 1. While out_valid=1 and out_ready=0 the
// head (out_data/out_channel) holds steady. A word pushed on one edge is
// visible at the head no earlier than the following cycle.
// ---------------------------------------------------------------------------
module audio_adc_capture #(
  parameter int SAMPLE_W   = 24,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int MODE       = 0
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          audio_interface_BCLK,
  input  logic                          audio_interface_ADCLRCK,
  input  logic                          audio_interface_ADCDAT,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SAMPLE_W-1:0]           out_data,
  output logic                          out_channel,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [1:0]                    fsm_state
`ifdef AUDIO_ADC_CAPTURE_LEVEL_METER_EN
  ,
  input  logic                          peak_clr,
  output logic [SAMPLE_W-2:0]           peak_l,
  output logic [SAMPLE_W-2:0]           peak_r
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]         FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]         CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]       PTR_ONE  = AW'(1);
  localparam logic [SAMPLE_W-1:0] MASK_MSB = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // Synchronisers and edge detection
  // -------------------------------------------------------------------------
  logic [1:0] bclk_sync, lrck_sync, dat_sync;
  logic       bclk_d, lrck_d;
  logic       bclk_rise, lrck_edge, lrck_now, dat_now;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bclk_sync <= 2'b00;
      lrck_sync <= 2'b00;
      dat_sync  <= 2'b00;
      bclk_d    <= 1'b0;
      lrck_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], audio_interface_BCLK};
      lrck_sync <= {lrck_sync[0], audio_interface_ADCLRCK};
      dat_sync  <= {dat_sync[0], audio_interface_ADCDAT};
      bclk_d    <= bclk_sync[1];
      lrck_d    <= lrck_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_d;
  assign lrck_edge = lrck_sync[1] ^ lrck_d;
  assign lrck_now  = lrck_sync[1];
  assign dat_now   = dat_sync[1];

  // -------------------------------------------------------------------------
  // Capture FSM
  // The shift register is filled MSB first by OR-ing in a one-hot bit mask
  // that walks from MSB to LSB. The word is therefore always left-aligned
  // with zero LSBs, which gives the partial-word format on an early frame
  // edge for free. mask[0] set means the current bit is the last one.
  // -------------------------------------------------------------------------
  state_e              state, state_next;
  logic [SAMPLE_W-1:0] shreg, shreg_next, shreg_bit;
  logic [SAMPLE_W-1:0] mask, mask_next;
  logic                chan, chan_next;
  logic                word_push;
  logic [SAMPLE_W-1:0] word_data;
  logic                word_chan;
  logic                push;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
      shreg <= '0;
      mask  <= MASK_MSB;
      chan  <= 1'b0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      mask  <= mask_next;
      chan  <= chan_next;
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    mask_next  = mask;
    chan_next  = chan;
    word_push  = 1'b0;
    word_data  = shreg;
    word_chan  = chan;
    shreg_bit  = dat_now ? (shreg | mask) : shreg;

    if (lrck_edge) begin
      // A frame edge before the slot completed flushes what we have.
      if (state == SKIP || state == SHIFT) begin
        word_push = 1'b1;
      end
      chan_next  = lrck_now;
      shreg_next = '0;
      mask_next  = MASK_MSB;
      state_next = (MODE == 0) ? SKIP : SHIFT;
    end else if (bclk_rise) begin
      case (state)
        SKIP: state_next = SHIFT;
        SHIFT: begin
          shreg_next = shreg_bit;
          mask_next  = mask >> 1;
          if (mask[0]) begin
            word_push  = 1'b1;
            word_data  = shreg_bit;
            state_next = HOLD;
          end
        end
        default: ;
      endcase
    end
  end

  assign fsm_state = state;

  // Mono builds never store right-channel words.
  assign push = word_push && !((CHANNELS == 1) && word_chan);

  // -------------------------------------------------------------------------
  // Sample FIFO
  // -------------------------------------------------------------------------
  logic [SAMPLE_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, pop, wr_en;

  assign full  = (count == FULL_CNT);
  assign pop   = out_valid && out_ready;
  // When full, a pop in the same cycle frees the slot for the new word.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {word_chan, word_data};
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      // A new drop wins over a clear in the same cycle.
      if (push && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

  assign out_valid  = (count != '0);
  assign fill_level = count;

  always_comb begin
    {out_channel, out_data} = out_valid ? mem[rd_ptr] : '0;
  end

`ifdef AUDIO_ADC_CAPTURE_LEVEL_METER_EN
  // -------------------------------------------------------------------------
  // Level meter: magnitude of each produced word, most-negative value
  // saturates to the largest positive magnitude.
  // -------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] neg_word;
  logic [SAMPLE_W-2:0] mag;

  assign neg_word = -word_data;
  assign mag = word_data[SAMPLE_W-1]
             ? (neg_word[SAMPLE_W-1] ? {(SAMPLE_W-1){1'b1}} : neg_word[SAMPLE_W-2:0])
             : word_data[SAMPLE_W-2:0];

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      peak_l <= '0;
      peak_r <= '0;
    end else if (peak_clr) begin
      peak_l <= (push && !word_chan) ? mag : '0;
      peak_r <= (push &&  word_chan) ? mag : '0;
    end else if (push) begin
      if (word_chan) begin
        if (mag > peak_r) peak_r <= mag;
      end else begin
        if (mag > peak_l) peak_l <= mag;
      end
    end
  end
`endif

endmodule

// File: tb/tb_audio_adc_capture.sv
// ---------------------------------------------------------------------------
// tb_audio_adc_capture
//   Directed bench for audio_adc_capture. Three instances share the serial
//   lines and the reset:
//     u0: SAMPLE_W=24, CHANNELS=2, FIFO_DEPTH=4,  MODE=0 (I2S)
//     u1: SAMPLE_W=16, CHANNELS=2, FIFO_DEPTH=16, MODE=1 (left-justified)
//     u2: SAMPLE_W=8,  CHANNELS=1, FIFO_DEPTH=4,  MODE=1
//   Each scenario resets all three and checks only the instance it targets.
// ---------------------------------------------------------------------------
module tb_audio_adc_capture;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic bclk = 1'b0, lrck = 1'b0, dat = 1'b0;
  logic ready0 = 1'b0, ready1 = 1'b0, ready2 = 1'b0;
  logic ovf_clr = 1'b0;

  logic        v0, c0, o0;  logic [23:0] d0; logic [2:0] f0; logic [1:0] s0;
  logic        v1, c1, o1;  logic [15:0] d1; logic [4:0] f1; logic [1:0] s1;
  logic        v2, c2, o2;  logic [7:0]  d2; logic [2:0] f2; logic [1:0] s2;
`ifdef AUDIO_ADC_CAPTURE_LEVEL_METER_EN
  logic peak_clr = 1'b0;
  logic [22:0] pl0, pr0;
  logic [14:0] pl1, pr1;
  logic [6:0]  pl2, pr2;
`endif

  audio_adc_capture #(.SAMPLE_W(24), .CHANNELS(2), .FIFO_DEPTH(4), .MODE(0)) u0 (
    .clk_clk(clk), .reset_reset(rst),
    .audio_interface_BCLK(bclk), .audio_interface_ADCLRCK(lrck), .audio_interface_ADCDAT(dat),
    .out_valid(v0), .out_ready(ready0), .out_data(d0), .out_channel(c0),
    .overflow(o0), .ovf_clr(ovf_clr), .fill_level(f0), .fsm_state(s0)
`ifdef AUDIO_ADC_CAPTURE_LEVEL_METER_EN
    , .peak_clr(peak_clr), .peak_l(pl0), .peak_r(pr0)
`endif
  );

  audio_adc_capture #(.SAMPLE_W(16), .CHANNELS(2), .FIFO_DEPTH(16), .MODE(1)) u1 (
    .clk_clk(clk), .reset_reset(rst),
    .audio_interface_BCLK(bclk), .audio_interface_ADCLRCK(lrck), .audio_interface_ADCDAT(dat),
    .out_valid(v1), .out_ready(ready1), .out_data(d1), .out_channel(c1),
    .overflow(o1), .ovf_clr(ovf_clr), .fill_level(f1), .fsm_state(s1)
`ifdef AUDIO_ADC_CAPTURE_LEVEL_METER_EN
    , .peak_clr(peak_clr), .peak_l(pl1), .peak_r(pr1)
`endif
  );

  audio_adc_capture #(.SAMPLE_W(8), .CHANNELS(1), .FIFO_DEPTH(4), .MODE(1)) u2 (
    .clk_clk(clk), .reset_reset(rst),
    .audio_interface_BCLK(bclk), .audio_interface_ADCLRCK(lrck), .audio_interface_ADCDAT(dat),
    .out_valid(v2), .out_ready(ready2), .out_data(d2), .out_channel(c2),
    .overflow(o2), .ovf_clr(ovf_clr), .fill_level(f2), .fsm_state(s2)
`ifdef AUDIO_ADC_CAPTURE_LEVEL_METER_EN
    , .peak_clr(peak_clr), .peak_l(pl2), .peak_r(pr2)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;
  logic [24:0] exp_q[$];   // {channel, data} expected at u0's FIFO head

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
    ready0 = 1'b0; ready1 = 1'b0; ready2 = 1'b0; ovf_clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One BCLK period: 4 clk low (data changes), 4 clk high.
  // With pop_at_push set, u0's out_ready is pulsed for the single cycle in
  // which the rising edge reaches the FIFO (2 sync flops, then the push edge).
  task automatic bclk_cycle(input logic b, input bit pop_at_push);
    bclk = 1'b0;
    dat  = b;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    if (pop_at_push) begin
      repeat (2) @(negedge clk);
      ready0 = 1'b1;
      @(negedge clk);
      ready0 = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  // One frame slot: set ADCLRCK, optional I2S delay bit, then nbits MSB first.
  task automatic slot(input logic ch, input logic [31:0] val, input int nbits,
                      input bit i2s, input bit pop_last);
    lrck = ch;
    if (i2s) bclk_cycle(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++)
      bclk_cycle(val[nbits-1-i], pop_last && (i == nbits-1));
    if (nbits == 0 && !i2s) bclk_cycle(1'b0, 1'b0);
  endtask

  // Pop u0's head and compare with the scoreboard.
  task automatic pop0(input string tag);
    logic [24:0] exp;
    for (int k = 0; k < 64 && !v0; k++) @(negedge clk);
    check({tag, "_valid"}, 32'(v0), 32'd1);
    exp = exp_q.pop_front();
    check(tag, 32'({c0, d0}), 32'(exp));
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_data",  32'(d0), 32'd0);
    check("rst_chan",  32'(c0), 32'd0);
    check("rst_ovf",   32'(o0), 32'd0);
    check("rst_fill",  32'(f0), 32'd0);
    check("rst_state", 32'(s0), 32'd0);

    // I2S 24-bit: right slot then left slot 0x123456
    slot(1'b1, 32'h0A0B0C, 24, 1'b1, 1'b0);
    slot(1'b0, 32'h123456, 24, 1'b1, 1'b0);
    check("i2s_fill", 32'(f0), 32'd2);
    check("i2s_state_hold", 32'(s0), 32'd3);
    exp_q.push_back({1'b1, 24'h0A0B0C});
    exp_q.push_back({1'b0, 24'h123456});
    pop0("i2s_right");
    pop0("i2s_left");

    // Left-justified 16-bit on u1: 32-bit right slot truncates to 0xABCD
    do_reset();
    slot(1'b1, 32'hABCD_FFFF, 32, 1'b0, 1'b0);
    check("lj_fill", 32'(f1), 32'd1);
    check("lj_data", 32'(d1), 32'hABCD);
    check("lj_chan", 32'(c1), 32'd1);
    check("lj_state_hold", 32'(s1), 32'd3);

    // Short slot: 20 ones then an ADCLRCK edge -> 0xFFFFF0
    do_reset();
    slot(1'b1, 32'h111111, 24, 1'b1, 1'b0);
    slot(1'b0, 32'hFFFFF, 20, 1'b1, 1'b0);
    slot(1'b1, 32'h0, 0, 1'b1, 1'b0);
    exp_q.push_back({1'b1, 24'h111111});
    exp_q.push_back({1'b0, 24'hFFFFF0});
    pop0("short_first");
    pop0("short_partial");

    // Overflow: 5 words into a 4-deep FIFO with no consumer
    do_reset();
    slot(1'b1, 32'h100001, 24, 1'b1, 1'b0);
    slot(1'b0, 32'h200002, 24, 1'b1, 1'b0);
    slot(1'b1, 32'h300003, 24, 1'b1, 1'b0);
    check("ovf_not_yet", 32'(o0), 32'd0);
    slot(1'b0, 32'h400004, 24, 1'b1, 1'b0);
    slot(1'b1, 32'h500005, 24, 1'b1, 1'b0);
    check("ovf_fill", 32'(f0), 32'd4);
    check("ovf_flag", 32'(o0), 32'd1);
    check("ovf_head", 32'({c0, d0}), 32'h1100001);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(o0), 32'd0);

    // Full FIFO: push and pop in the same cycle
    exp_q.push_back({1'b0, 24'h200002});
    exp_q.push_back({1'b1, 24'h300003});
    exp_q.push_back({1'b0, 24'h400004});
    exp_q.push_back({1'b0, 24'h600006});
    slot(1'b0, 32'h600006, 24, 1'b1, 1'b1);
    check("fullpp_fill", 32'(f0), 32'd4);
    check("fullpp_ovf",  32'(o0), 32'd0);
    pop0("fullpp_w2");
    pop0("fullpp_w3");
    pop0("fullpp_w4");
    pop0("fullpp_new");
    check("fullpp_empty", 32'(f0), 32'd0);

    // Reset mid-frame discards the partial word
    do_reset();
    slot(1'b1, 32'h0F0F0F, 24, 1'b1, 1'b0);
    lrck = 1'b0;
    for (int i = 0; i < 6; i++) bclk_cycle(1'b1, 1'b0);
    do_reset();
    check("midrst_fill",  32'(f0), 32'd0);
    check("midrst_state", 32'(s0), 32'd0);
    slot(1'b1, 32'h654321, 24, 1'b1, 1'b0);
    check("midrst_fill2", 32'(f0), 32'd1);
    exp_q.push_back({1'b1, 24'h654321});
    pop0("midrst_word");

    // Mono build on u2: right words discarded
    do_reset();
    slot(1'b1, 32'hAA, 8, 1'b0, 1'b0);
    check("mono_right_drop", 32'(f2), 32'd0);
    slot(1'b0, 32'h5A, 8, 1'b0, 1'b0);
    check("mono_fill", 32'(f2), 32'd1);
    check("mono_data", 32'(d2), 32'h5A);
    check("mono_chan", 32'(c2), 32'd0);

`ifdef AUDIO_ADC_CAPTURE_LEVEL_METER_EN
    // Level meter on u0
    do_reset();
    ready0 = 1'b1;
    slot(1'b1, 32'h000050, 24, 1'b1, 1'b0);
    slot(1'b0, 32'h000100, 24, 1'b1, 1'b0);
    check("peak_l_small", 32'(pl0), 32'h100);
    slot(1'b1, 32'hFFFFFE, 24, 1'b1, 1'b0);
    slot(1'b0, 32'h800000, 24, 1'b1, 1'b0);
    check("peak_l_sat", 32'(pl0), 32'h7FFFFF);
    check("peak_r", 32'(pr0), 32'h50);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    check("peak_l_clr", 32'(pl0), 32'd0);
    check("peak_r_clr", 32'(pr0), 32'd0);
    ready0 = 1'b0;
`endif

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $display("test done: total=%0d bad=%0d", n_checks, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
